// File: rtl/register_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : register_writeback_pkg
// Brief    : Shared register-file types and constants used by the writeback
//            stage and the register file.
// Revision : 1.0 - initial release
// ============================================================================
package register_writeback_pkg;

  localparam int RegisterAddressWidth = 5;
  localparam int RegisterDataWidth    = 32;

  // Single register-file write port.
  typedef struct packed {
    logic                            enable;
    logic [RegisterAddressWidth-1:0] address;
    logic [RegisterDataWidth-1:0]    data;
  } register_file_write_t;

  // A result waiting to be written back.
  typedef struct packed {
    logic [RegisterAddressWidth-1:0] address;
    logic [RegisterDataWidth-1:0]    data;
  } writeback_result_t;

endpackage
`default_nettype wire

// File: rtl/register_writeback_fifo.sv
`default_nettype none
// ============================================================================
// Module   : writeback_fifo
// Brief    : Power-of-two depth FIFO for writeback results. Pointers carry one
//            extra wrap bit so that full and empty can be told apart. Storage
//            is not reset; only the pointers are.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_fifo #(
  parameter int  Depth  = 4,
  parameter type elem_t = logic [31:0]
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  elem_t data_i,
  input  logic  pop_i,
  output elem_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int IdxWidth = $clog2(Depth);

  logic [IdxWidth:0] wr_ptr_q, wr_ptr_d;
  logic [IdxWidth:0] rd_ptr_q, rd_ptr_d;
  elem_t             mem_q [Depth];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IdxWidth] != rd_ptr_q[IdxWidth]) &&
                   (wr_ptr_q[IdxWidth-1:0] == rd_ptr_q[IdxWidth-1:0]);
  assign data_o  = mem_q[rd_ptr_q[IdxWidth-1:0]];

  // Advance pointers on push/pop; the wrap bit rolls over naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + (IdxWidth + 1)'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + (IdxWidth + 1)'(1);
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data storage, never reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[IdxWidth-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/register_writeback.sv
`default_nettype none
// ============================================================================
// Module   : register_writeback
// Brief    : Merges execute results (single-entry skid) and load results
//            (FIFO) onto one registered register-file write port with a
//            round-robin arbiter. Writes to x0 are drained silently.
//            Optional pending-write scoreboard: WRITEBACK_SCOREBOARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module register_writeback
  import register_writeback_pkg::*;
#(
  parameter int RegisterCount  = 32,
  parameter int LoadQueueDepth = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            exec_valid_i,
  output logic                            exec_ready_o,
  input  logic [RegisterAddressWidth-1:0] exec_address_i,
  input  logic [RegisterDataWidth-1:0]    exec_data_i,
  input  logic                            load_valid_i,
  output logic                            load_ready_o,
  input  logic [RegisterAddressWidth-1:0] load_address_i,
  input  logic [RegisterDataWidth-1:0]    load_data_i,
  input  logic                            reserve_i,
  input  logic [RegisterAddressWidth-1:0] reserve_address_i,
  output register_file_write_t            write_o,
  output logic [RegisterCount-1:0]        pending_o
);

  logic              skid_valid_q, skid_valid_d;
  writeback_result_t skid_q;
  writeback_result_t fifo_head;
  logic              fifo_full, fifo_empty;
  logic              exec_fire, load_fire;
  logic              grant_exec, grant_load;
  logic              prefer_exec_q, prefer_exec_d;
  logic              write_enable_q, write_enable_d;
  writeback_result_t write_result_q, write_result_d;

  // A slot frees up in the same cycle its head is granted.
  assign exec_ready_o = !skid_valid_q || grant_exec;
  assign load_ready_o = !fifo_full || grant_load;
  assign exec_fire    = exec_valid_i && exec_ready_o;
  assign load_fire    = load_valid_i && load_ready_o;
  assign skid_valid_d = exec_fire || (skid_valid_q && !grant_exec);

  writeback_fifo #(
    .Depth  (LoadQueueDepth),
    .elem_t (writeback_result_t)
  ) u_load_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (load_fire),
    .data_i  ('{address: load_address_i, data: load_data_i}),
    .pop_i   (grant_load),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Round-robin arbiter: the pointer only flips on a contended grant, so a
  // lone source never steals the next turn from the other one.
  always_comb begin
    grant_exec    = 1'b0;
    grant_load    = 1'b0;
    prefer_exec_d = prefer_exec_q;
    if (skid_valid_q && !fifo_empty) begin
      grant_exec    = prefer_exec_q;
      grant_load    = !prefer_exec_q;
      prefer_exec_d = !prefer_exec_q;
    end else if (skid_valid_q) begin
      grant_exec = 1'b1;
    end else if (!fifo_empty) begin
      grant_load = 1'b1;
    end
  end

  // Granted entry goes to the output register; x0 drains without a write.
  assign write_result_d = grant_exec ? skid_q : fifo_head;
  assign write_enable_d = (grant_exec || grant_load) && (write_result_d.address != '0);

  // Control state with asynchronous reset (next grant after reset = load).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_valid_q   <= 1'b0;
      prefer_exec_q  <= 1'b0;
      write_enable_q <= 1'b0;
    end else begin
      skid_valid_q   <= skid_valid_d;
      prefer_exec_q  <= prefer_exec_d;
      write_enable_q <= write_enable_d;
    end
  end

  // Datapath registers, intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (exec_fire) skid_q <= '{address: exec_address_i, data: exec_data_i};
    write_result_q <= write_result_d;
  end

  assign write_o.enable  = write_enable_q;
  assign write_o.address = write_result_q.address;
  assign write_o.data    = write_result_q.data;

`ifdef WRITEBACK_SCOREBOARD_EN
  logic [RegisterCount-1:0] pending_q, pending_d;

  // Clear on write, then set on reserve so a same-cycle reserve wins.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < RegisterCount; i++) begin
      if (write_enable_q && (write_result_q.address == RegisterAddressWidth'(i)))
        pending_d[i] = 1'b0;
      if (reserve_i && (reserve_address_i == RegisterAddressWidth'(i)))
        pending_d[i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  assign pending_o = pending_q;

`ifndef SYNTHESIS
  a_write_was_reserved : assert property (@(posedge clk_i) disable iff (!rst_ni)
    write_enable_q |-> pending_q[write_result_q.address]);
`endif
`else
  logic unused_reserve;
  assign unused_reserve = ^{reserve_i, reserve_address_i};
  assign pending_o      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_writeback
// Brief    : Self-checking bench for register_writeback: directed scenarios
//            plus randomized traffic checked against a per-source queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_writeback;
  import register_writeback_pkg::*;

  localparam int Depth = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 exec_valid = 1'b0, load_valid = 1'b0, reserve = 1'b0;
  logic                 exec_ready, load_ready;
  logic [4:0]           exec_addr = '0, load_addr = '0, reserve_addr = '0;
  logic [31:0]          exec_data = '0, load_data = '0;
  register_file_write_t write_o;
  logic [31:0]          pending;

  register_writeback #(.RegisterCount(32), .LoadQueueDepth(Depth)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .exec_valid_i(exec_valid), .exec_ready_o(exec_ready),
    .exec_address_i(exec_addr), .exec_data_i(exec_data),
    .load_valid_i(load_valid), .load_ready_o(load_ready),
    .load_address_i(load_addr), .load_data_i(load_data),
    .reserve_i(reserve), .reserve_address_i(reserve_addr),
    .write_o(write_o), .pending_o(pending)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: each source is an in-order queue of results still owed
  // to the register file; x0 results owe nothing and are never queued.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exec_q[$];
  exp_t load_q[$];
  int   cyc = 0;
  bit   bp_check = 1'b0;
  bit   saw_ready_low = 1'b0;
  bit   acc_e = 1'b0, acc_l = 1'b0;

  always @(negedge clk) begin
    bit found;
    int lat;
    cyc++;
    acc_e = exec_valid && exec_ready;
    acc_l = load_valid && load_ready;
    if (!rst_n) begin
      exec_q.delete();
      load_q.delete();
    end else begin
      if (write_o.enable) begin
        found = 1'b0;
        lat   = 0;
        if (exec_q.size() > 0 && exec_q[0].addr == write_o.address && exec_q[0].data == write_o.data) begin
          lat = cyc - exec_q[0].cyc;
          void'(exec_q.pop_front());
          found = 1'b1;
        end else if (load_q.size() > 0 && load_q[0].addr == write_o.address && load_q[0].data == write_o.data) begin
          lat = cyc - load_q[0].cyc;
          void'(load_q.pop_front());
          found = 1'b1;
        end
        check_eq("write_is_next_owed_result", found, 1);
        if (found) check_eq("write_latency_at_least_2", lat >= 2, 1);
      end
      if (bp_check && !load_ready) begin
        saw_ready_low = 1'b1;
        check_eq("load_ready_low_only_when_full", load_q.size(), Depth);
      end
`ifndef WRITEBACK_SCOREBOARD_EN
      check_eq("pending_tied_zero", pending, 0);
`endif
      if (acc_e && exec_addr != 0) exec_q.push_back('{exec_addr, exec_data, cyc});
      if (acc_l && load_addr != 0) load_q.push_back('{load_addr, load_data, cyc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    check_eq({tag, "_enable"}, write_o.enable, en);
    if (en) begin
      check_eq({tag, "_address"}, write_o.address, a);
      check_eq({tag, "_data"}, write_o.data, d);
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exec_q.size() != 0 || load_q.size() != 0) && k < 40) begin
      step();
      k++;
    end
    check_eq({tag, "_exec_results_lost"}, exec_q.size(), 0);
    check_eq({tag, "_load_results_lost"}, load_q.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    logic [31:0] pend_snap;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_exec_ready", exec_ready, 1);
    check_eq("reset_load_ready", load_ready, 1);
    check_eq("reset_write_enable", write_o.enable, 0);
    check_eq("reset_pending", pending, 0);

    // Release reset and offer exec x5 for the first edge.
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    exec_valid = 1'b1; exec_addr = 5'd5; exec_data = 32'hDEADBEEF;
    #1;
    check_eq("post_reset_exec_ready", exec_ready, 1);
    check_eq("post_reset_load_ready", load_ready, 1);

`ifdef WRITEBACK_SCOREBOARD_EN
    // Reserve x5 so the write-back is legal, then continue with x7 scenario.
    reserve = 1'b1; reserve_addr = 5'd5;
`endif
    step();
    exec_valid = 1'b0; reserve = 1'b0;
    check_write("exec_not_early", 1'b0, 5'd0, 32'd0);
    step();
    check_write("exec_x5_write", 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    check_write("exec_x5_one_cycle", 1'b0, 5'd0, 32'd0);

`ifdef WRITEBACK_SCOREBOARD_EN
    // Reserve x7, write it from load while re-reserving, then write it again.
    reserve = 1'b1; reserve_addr = 5'd7;
    step();
    reserve = 1'b0;
    check_eq("sb_reserve_sets", pending[7], 1);
    load_valid = 1'b1; load_addr = 5'd7; load_data = 32'h77;
    step();
    load_valid = 1'b0;
    step();
    check_write("sb_load_x7", 1'b1, 5'd7, 32'h77);
    reserve = 1'b1; reserve_addr = 5'd7;
    step();
    reserve = 1'b0;
    check_eq("sb_set_wins_over_clear", pending[7], 1);
    exec_valid = 1'b1; exec_addr = 5'd7; exec_data = 32'h78;
    step();
    exec_valid = 1'b0;
    step();
    check_write("sb_exec_x7", 1'b1, 5'd7, 32'h78);
    check_eq("sb_pending_before_clear", pending[7], 1);
    step();
    check_eq("sb_write_clears", pending[7], 0);
    check_eq("sb_x0_never_pending", pending[0], 0);
    drain("sb");
`else
    // Contention right after reset: load goes first.
    step();
    exec_valid = 1'b1; exec_addr = 5'd3; exec_data = 32'h11;
    load_valid = 1'b1; load_addr = 5'd4; load_data = 32'h22;
    step();
    exec_valid = 1'b0; load_valid = 1'b0;
    step();
    check_write("cont1_first_load", 1'b1, 5'd4, 32'h22);
    step();
    check_write("cont1_then_exec", 1'b1, 5'd3, 32'h11);
    step();
    check_write("cont1_idle", 1'b0, 5'd0, 32'd0);
    // Repeat contention: exec now has the turn.
    exec_valid = 1'b1; exec_addr = 5'd3; exec_data = 32'h33;
    load_valid = 1'b1; load_addr = 5'd4; load_data = 32'h44;
    step();
    exec_valid = 1'b0; load_valid = 1'b0;
    step();
    check_write("cont2_first_exec", 1'b1, 5'd3, 32'h33);
    step();
    check_write("cont2_then_load", 1'b1, 5'd4, 32'h44);
    step();

    // x0 result is accepted but never written.
    pend_snap = pending;
    exec_valid = 1'b1; exec_addr = 5'd0; exec_data = 32'hFFFFFFFF;
    #1;
    check_eq("x0_accepted", exec_ready, 1);
    step();
    exec_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("x0_no_write", write_o.enable, 0);
    end
    check_eq("x0_pending_unchanged", pending, pend_snap);

    // Backpressure: continuous loads and execs, nonzero destinations.
    bp_check = 1'b1;
    saw_ready_low = 1'b0;
    exec_valid = 1'b1; exec_addr = 5'($urandom_range(1, 31)); exec_data = $urandom;
    load_valid = 1'b1; load_addr = 5'($urandom_range(1, 31)); load_data = $urandom;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc_e) begin exec_addr = 5'($urandom_range(1, 31)); exec_data = $urandom; end
      if (acc_l) begin load_addr = 5'($urandom_range(1, 31)); load_data = $urandom; end
    end
    exec_valid = 1'b0; load_valid = 1'b0;
    step();
    bp_check = 1'b0;
    check_eq("bp_load_ready_went_low", saw_ready_low, 1);
    drain("bp");

    // Randomized mixed traffic including x0 and ignored reservations.
    for (int i = 0; i < 400; i++) begin
      exec_valid   = ($urandom_range(0, 99) < 55);
      exec_addr    = 5'($urandom_range(0, 31));
      exec_data    = $urandom;
      load_valid   = ($urandom_range(0, 99) < 45);
      load_addr    = 5'($urandom_range(0, 31));
      load_data    = $urandom;
      reserve      = $urandom_range(0, 1) == 1;
      reserve_addr = 5'($urandom_range(0, 31));
      step();
    end
    exec_valid = 1'b0; load_valid = 1'b0; reserve = 1'b0;
    drain("rand");

    // Reset mid-flight with the FIFO partly full and the skid occupied.
    exec_valid = 1'b1; exec_addr = 5'd9;  exec_data = 32'h9;
    load_valid = 1'b1; load_addr = 5'd10; load_data = 32'hA;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      step();
      if (acc_e) exec_data = exec_data + 1;
      if (acc_l) load_data = load_data + 1;
      if (load_q.size() >= 4 && !exec_ready) reached = 1'b1;
    end
    check_eq("rst_setup_reached", reached, 1);
    rst_n = 1'b0;
    exec_valid = 1'b0; load_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("midrst_exec_ready", exec_ready, 1);
      check_eq("midrst_load_ready", load_ready, 1);
      check_eq("midrst_write_enable", write_o.enable, 0);
      check_eq("midrst_pending", pending, 0);
      step();
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check_eq("after_rst_exec_ready", exec_ready, 1);
    check_eq("after_rst_load_ready", load_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("after_rst_no_write", write_o.enable, 0);
    end
    check_eq("after_rst_pending", pending, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_writeback.md
REGISTER_WRITEBACK -- requirements
Module: register_writeback

Interface
REQ-001 SHALL have parameter RegisterCount, default 32, number of architectural registers tracked.
REQ-002 SHALL have parameter LoadQueueDepth, default 4, load-result FIFO entries (power of two, >= 2).
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports: clk_i (input, 1, clock) then rst_ni (input, 1, async active-low reset).
REQ-004 SHALL have exec_valid_i (input, 1): execute result offered.
REQ-005 SHALL have exec_ready_o (output, 1): execute result accepted this cycle when exec_valid_i is also high.
REQ-006 SHALL have exec_address_i (input, 5) and exec_data_i (input, 32): destination and value.
REQ-007 SHALL have load_valid_i, load_ready_o, load_address_i[4:0] and load_data_i[31:0]: the same handshake for load results.
REQ-008 SHALL have reserve_i (input, 1) and reserve_address_i (input, 5): issue stage marks a destination as pending.
REQ-009 SHALL have write_o (output, register_file_write_t: enable, address, data): the single register-file write port.
REQ-010 SHALL have pending_o (output, RegisterCount): per-register outstanding-write mask.

Function
REQ-011 SHALL transfer on a channel only when valid and ready are both high at a rising edge.
REQ-012 SHALL hold one execute result in a single-entry skid register; exec_ready_o is high when the skid is empty or is granted this cycle.
REQ-013 SHALL hold load results in a LoadQueueDepth FIFO; load_ready_o is high when not full, and also when full with the head granted this cycle.
REQ-014 SHALL arbitrate the skid head and FIFO head round-robin: with both pending, grant the source not granted last; with one pending, grant it.
REQ-015 SHALL drive the grant onto write_o registered: a result accepted at edge N appears on write_o in the cycle after edge N+1 at the earliest (1 cycle skid + 1 cycle output), and write_o.enable lasts exactly one cycle per grant.
REQ-016 SHALL drain a granted entry whose address is 0 without a write: write_o.enable=0, and the round-robin pointer still updates.
REQ-017 SHALL drive write_o.enable=0 in any cycle without a grant; address and data are then don't-care.
REQ-018 SHALL set pending_o[a] at the edge where reserve_i is high, for a != 0; pending_o[0] is constantly 0.
REQ-019 SHALL clear pending_o[a] at the edge where write_o.enable=1 with write_o.address=a.
REQ-020 SHALL let set win when a reserve and a clear hit the same address in the same cycle.
REQ-021 SHALL wrap FIFO pointers modulo LoadQueueDepth, with full/empty distinguished by an extra pointer bit.
REQ-022 SHALL preserve order within each source; no ordering between sources is guaranteed.

Reset
REQ-023 SHALL asynchronously clear on rst_ni low: skid valid, FIFO pointers, round-robin pointer (next grant = load), write_o.enable, and pending_o (all zero).
REQ-024 SHALL drive exec_ready_o=1 and load_ready_o=1 while in reset and in the first cycle after it.
REQ-025 SHALL discard all buffered results and reservations when reset asserts mid-operation.
REQ-026 SHALL not reset write_o.address, write_o.data or the FIFO/skid data storage.

Configuration
REQ-027 SHALL compile the scoreboard only when WRITEBACK_SCOREBOARD_EN is defined. Without it: pending_o is tied to 0, reserve_i is ignored, and there is no scoreboard storage.
REQ-028 SHALL, when WRITEBACK_SCOREBOARD_EN is defined and SYNTHESIS is not, assert that write_o.enable=1 only targets an address whose pending_o bit is set.

Structure
REQ-029 SHALL take register_file_write_t from the shared register-file package. New shared items belong in that package: writeback_result_t {address[4:0], data[31:0]} and the constant RegisterAddressWidth=5.
REQ-030 SHALL place the load FIFO in sub-module writeback_fifo, parameterised by depth and element type; skid, arbiter and scoreboard stay in register_writeback.

Verification
REQ-031 Exec only: exec x5=0xDEADBEEF accepted at edge 1 -> write_o {1,5,0xDEADBEEF} in the cycle after edge 2, enable low in the following cycle.
REQ-032 Contention: exec x3=0x11 and load x4=0x22 accepted the same edge after reset -> load written first, exec next cycle; a repeat contention then grants exec first.
REQ-033 Backpressure: 4 load results with continuous exec traffic -> load_ready_o low at 4 entries, FIFO order preserved, 0 results lost or duplicated.
REQ-034 x0: exec to x0 with 0xFFFFFFFF -> accepted, write_o.enable stays 0, pending_o unchanged.
REQ-035 Scoreboard (macro on): reserve x7 -> pending_o[7]=1; load writes x7 while reserve x7 is re-asserted the same cycle -> pending_o[7] stays 1; next write to x7 -> 0.
REQ-036 Reset mid-flight: rst_ni low with 3 FIFO entries and skid full -> no write_o.enable after release, pending_o=0, both readies high.
